// File: rtl/example_reg_initiator_pkg.sv
// Shared types and constants for the example register-bus initiator.
package example_reg_initiator_pkg;

  localparam int unsigned ADDR_W   = example_sv_pkg::addr_width;
  localparam int unsigned DATA_W   = example_sv_pkg::data_width;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } initiator_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              uninit;
  } initiator_rsp_t;

  // Registers without a reset value are the complement of the generated list.
  localparam logic [NUM_REGS-1:0] DEFAULT_UNRESET_MASK = ~example_sv_pkg::reg_has_reset;

  function automatic logic rd_uninit(input logic [NUM_REGS-1:0] mask,
                                     input logic [NUM_REGS-1:0] written,
                                     input logic [ADDR_W-1:0]   addr);
    return mask[addr] & ~written[addr];
  endfunction

endpackage : example_reg_initiator_pkg

// File: rtl/example_sv_pkg.sv
// Generated register-bank constants for the `example` bank.
// Bit i of reg_has_reset is 1 when register i is given a value by reset.
package example_sv_pkg;

  localparam int unsigned addr_width    = 3;
  localparam int unsigned data_width    = 32;
  localparam int unsigned num_regs      = 8;
  localparam logic [7:0]  reg_has_reset = 8'b1001_1111;

endpackage : example_sv_pkg

// File: rtl/example_reg_timeout.sv
// Loadable down-counter bounding how long the initiator waits for bus_ack.
// Loaded with TIMEOUT-1 so expired_o is high during the TIMEOUT-th wait cycle.
module example_reg_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over clear so an accept that coincides with a clear still arms the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule : example_reg_timeout

// File: rtl/example_reg_initiator.sv
// Single-outstanding bus initiator for the example register bank, with
// tracking of first writes to registers that have no reset value.
module example_reg_initiator
  import example_reg_initiator_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH   = ADDR_W,
  parameter int unsigned               DATA_WIDTH   = DATA_W,
  parameter int unsigned               TIMEOUT      = 15,
  parameter logic [(2**ADDR_WIDTH)-1:0] UNRESET_MASK = DEFAULT_UNRESET_MASK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_uninit,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  initiator_state_t      state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  initiator_rsp_t        rsp_q, rsp_d;
  logic                  uninit_pend_q, uninit_pend_d;
  logic [NREG-1:0]       written_q, written_d;

  logic cmd_accept;
  logic bus_done;
  logic bus_tmo;
  logic to_expired;

  assign cmd_accept = cmd_valid & cmd_ready_q;
  assign bus_done   = (state_q == REQ) & bus_ack;
  assign bus_tmo    = (state_q == REQ) & ~bus_ack & to_expired;

  example_reg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q == RSP),
    .load_i    (cmd_accept),
    .en_i      (state_q == REQ),
    .expired_o (to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) state_d = REQ;
        else            state_d = IDLE;
      end
      REQ: begin
        if (bus_done || bus_tmo) state_d = RSP;
        else                     state_d = REQ;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
        else           state_d = RSP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    bus_req_d     = (state_d == REQ);
    rsp_valid_d   = (state_d == RSP);
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    uninit_pend_d = uninit_pend_q;
    rsp_d         = rsp_q;
    written_d     = written_q;

    if (cmd_accept) begin
      bus_we_d      = cmd_write;
      bus_addr_d    = cmd_addr;
      bus_wdata_d   = cmd_wdata;
      uninit_pend_d = ~cmd_write & rd_uninit(UNRESET_MASK, written_q, cmd_addr);
    end else begin
      uninit_pend_d = uninit_pend_q;
    end

    if (bus_done) begin
      rsp_d.rdata  = bus_we_q ? {DATA_WIDTH{1'b0}} : bus_rdata;
      rsp_d.error  = 1'b0;
      rsp_d.uninit = uninit_pend_q;
      if (bus_we_q) written_d[bus_addr_q] = 1'b1;
      else          written_d = written_q;
    end else if (bus_tmo) begin
      rsp_d.rdata  = {DATA_WIDTH{1'b0}};
      rsp_d.error  = 1'b1;
      rsp_d.uninit = uninit_pend_q;
    end else begin
      rsp_d = rsp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_q   <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= {ADDR_WIDTH{1'b0}};
      bus_wdata_q   <= {DATA_WIDTH{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_q         <= '{rdata: {DATA_W{1'b0}}, error: 1'b0, uninit: 1'b0};
      uninit_pend_q <= 1'b0;
      written_q     <= {NREG{1'b0}};
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_q         <= rsp_d;
      uninit_pend_q <= uninit_pend_d;
      written_q     <= written_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_q.rdata;
  assign rsp_error  = rsp_q.error;
  assign rsp_uninit = rsp_q.uninit;

endmodule : example_reg_initiator

// File: tb/tb_example_reg_initiator.sv
// Directed, table-driven bench for example_reg_initiator.
module tb_example_reg_initiator;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_uninit;
  logic        bus_req, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  example_reg_initiator #(
    .ADDR_WIDTH   (3),
    .DATA_WIDTH   (32),
    .TIMEOUT      (TMO),
    .UNRESET_MASK (8'h60)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_uninit (rsp_uninit),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    int          ack_at;     // REQ cycle (1-based) in which ack is driven; 0 = never
    logic [31:0] bus_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_uninit;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"},  32'(cmd_ready),  32'd0);
    chk({tag, "_bus_req"},    32'(bus_req),    32'd0);
    chk({tag, "_bus_we"},     32'(bus_we),     32'd0);
    chk({tag, "_bus_addr"},   32'(bus_addr),   32'd0);
    chk({tag, "_bus_wdata"},  bus_wdata,       32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_rdata"},  rsp_rdata,       32'd0);
    chk({tag, "_rsp_error"},  32'(rsp_error),  32'd0);
    chk({tag, "_rsp_uninit"}, 32'(rsp_uninit), 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input int hold, input int idx);
    int    reqc;
    int    lat;
    int    w;
    int    exp_req;
    bit    got;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({t, "_ready_wait"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0F0F_0F0F;
    chk({t, "_bus_req"},   32'(bus_req),   32'd1);
    chk({t, "_bus_we"},    32'(bus_we),    32'(v.wr));
    chk({t, "_bus_addr"},  32'(bus_addr),  32'(v.addr));
    chk({t, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    if (v.wr) chk({t, "_bus_wdata"}, bus_wdata, v.wdata);
    reqc = 0;
    lat  = 1;
    got  = 1'b0;
    while (!got && lat < 40) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus_req) reqc++;
        if (bus_req && reqc == v.ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = v.bus_data;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = 32'hBAD0_0000 | 32'(reqc);
        end
        @(negedge clk);
        lat++;
      end
    end
    bus_ack = 1'b0;
    exp_req = (v.ack_at != 0) ? v.ack_at : TMO;
    chk({t, "_rsp_seen"},   32'(got),        32'd1);
    chk({t, "_req_cycles"}, 32'(reqc),       32'(exp_req));
    chk({t, "_latency"},    32'(lat),        32'(exp_req + 1));
    chk({t, "_rdata"},      rsp_rdata,       v.exp_rdata);
    chk({t, "_error"},      32'(rsp_error),  32'(v.exp_err));
    chk({t, "_uninit"},     32'(rsp_uninit), 32'(v.exp_uninit));
    chk({t, "_req_low"},    32'(bus_req),    32'd0);
    chk({t, "_rdy_low"},    32'(cmd_ready),  32'd0);
    // Hold the response back while pulsing stray acks.
    for (int h = 0; h < hold; h++) begin
      bus_ack   = h[0];
      bus_rdata = 32'h5555_0000 | 32'(h);
      @(negedge clk);
      chk({t, "_hold_valid"},  32'(rsp_valid),  32'd1);
      chk({t, "_hold_rdata"},  rsp_rdata,       v.exp_rdata);
      chk({t, "_hold_error"},  32'(rsp_error),  32'(v.exp_err));
      chk({t, "_hold_uninit"}, 32'(rsp_uninit), 32'(v.exp_uninit));
      chk({t, "_hold_ready"},  32'(cmd_ready),  32'd0);
      chk({t, "_hold_req"},    32'(bus_req),    32'd0);
    end
    bus_ack   = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({t, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({t, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  saw_rsp;
    int  saw_req;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 3'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;

    //               wr    addr  wdata          ack  bus_data       exp_rdata      err   uninit
    vecs[0]  = '{1'b0, 3'd1, 32'h0,         0,   32'h1111_1111, 32'h0,         1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'd5, 32'h0000_A5A5, 0,   32'h0,         32'h0,         1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd5, 32'h0,         1,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd2, 32'h0000_0035, 1,   32'hFFFF_0000, 32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd2, 32'h0,         1,   32'h0000_0035, 32'h0000_0035, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd5, 32'h0000_0077, 3,   32'h0,         32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 32'h0,         2,   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'd6, 32'h0000_0066, 0,   32'h0,         32'h0,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd6, 32'h0,         1,   32'h0000_CAFE, 32'h0000_CAFE, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'd5, 32'h0,         1,   32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd6, 32'h0,         TMO, 32'h6666_0006, 32'h6666_0006, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 3'd0, 32'hFFFF_FFFF, TMO, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd7, 32'h0,         14,  32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 3'd6, 32'h6060_6060, 2,   32'h0,         32'h0,         1'b0, 1'b0};
    vecs[14] = '{1'b0, 3'd6, 32'h0,         1,   32'h6060_6060, 32'h6060_6060, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 0, i);
    run_txn(vecs[7], 10, 7);
    run_txn(vecs[8], 0, 8);

    // Reset in the middle of a write to reg6: no response may follow.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd6;
    cmd_wdata = 32'h0000_0006;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_reset_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("mid_reset");
    saw_rsp = 0;
    saw_req = 0;
    for (int c = 0; c < 20; c++) begin
      bus_ack = (c == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (rsp_valid) saw_rsp++;
      if (bus_req)   saw_req++;
    end
    bus_ack = 1'b0;
    chk("mid_reset_no_rsp", 32'(saw_rsp), 32'd0);
    chk("mid_reset_no_req", 32'(saw_req), 32'd0);
    chk("mid_reset_ready",  32'(cmd_ready), 32'd1);

    for (int i = 9; i < 15; i++) run_txn(vecs[i], 0, i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_example_reg_initiator
